// File: rtl/mcycle_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes and FSM state type.
package mcycle_pkg;

  localparam logic MCYCLE_MUL = 1'b0;
  localparam logic MCYCLE_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mcycle_datapath.sv
// Shift-add multiplier / restoring divider.
// Advances one iteration per enable.
module mcycle_datapath
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] next_result
);

  // acc: product / remainder, sh: multiplicand / quotient,
  // aux: multiplier / divisor
  logic [WIDTH-1:0] acc, sh, aux;
  logic [WIDTH-1:0] acc_n, sh_n, aux_n;
  logic             op_q;
  logic [WIDTH:0]   rem_sh, diff;

  always_comb begin
    rem_sh = {acc, sh[WIDTH-1]};
    diff   = rem_sh - {1'b0, aux};
    acc_n  = acc;
    sh_n   = sh;
    aux_n  = aux;
    unique case (op_q)
      MCYCLE_MUL: begin
        acc_n = aux[0] ? acc + sh : acc;
        sh_n  = sh << 1;
        aux_n = aux >> 1;
      end
      MCYCLE_DIV: begin
        if (!diff[WIDTH]) begin
          acc_n = diff[WIDTH-1:0];
          sh_n  = {sh[WIDTH-2:0], 1'b1};
        end else begin
          acc_n = rem_sh[WIDTH-1:0];
          sh_n  = {sh[WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
    next_result = (op_q == MCYCLE_DIV) ? sh_n : acc_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      sh   <= '0;
      aux  <= '0;
      op_q <= MCYCLE_MUL;
    end else if (load) begin
      acc  <= '0;
      sh   <= opa;
      aux  <= opb;
      op_q <= op;
    end else if (en) begin
      acc <= acc_n;
      sh  <= sh_n;
      aux <= aux_n;
    end
  end

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle MUL/DIV unit for the Execute stage.
// FSM, iteration counter, destination latch and result register.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             M_Start,
  input  logic             M_Op,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [3:0]       WA3E,
  output logic             M_Busy,
  output logic             M_Done,
  output logic [WIDTH-1:0] M_Result,
  output logic [3:0]       WA3R
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             iter;
  logic             last;
  logic [WIDTH-1:0] next_result;

  // A start held through DONE is taken on the edge leaving DONE
  assign accept = M_Start && (state != RUN);
  assign iter   = (state == RUN);
  assign last   = iter && (cnt == CW'(WIDTH - 1));

  mcycle_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk        (CLK),
    .rst_n      (RESETn),
    .load       (accept),
    .en         (iter),
    .op         (M_Op),
    .opa        (Operand1),
    .opb        (Operand2),
    .next_result(next_result)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= IDLE;
      cnt      <= '0;
      M_Busy   <= 1'b0;
      M_Done   <= 1'b0;
      M_Result <= '0;
      WA3R     <= '0;
    end else begin
      M_Done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            state  <= RUN;
            cnt    <= '0;
            WA3R   <= WA3E;
            M_Busy <= 1'b1;
          end else begin
            state  <= IDLE;
            M_Busy <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state    <= DONE;
            M_Busy   <= 1'b0;
            M_Done   <= 1'b1;
            M_Result <= next_result;
          end
        end
        default: begin
          state  <= IDLE;
          M_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed checks for mcycle_unit.
// Each task drives one scenario and compares inline.
module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        M_Start = 1'b0;
  logic        M_Op = 1'b0;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic [3:0]  WA3E = '0;
  logic        M_Busy;
  logic        M_Done;
  logic [31:0] M_Result;
  logic [3:0]  WA3R;

  int passed = 0;
  int total = 0;

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .M_Start (M_Start),
    .M_Op    (M_Op),
    .Operand1(Operand1),
    .Operand2(Operand2),
    .WA3E    (WA3E),
    .M_Busy  (M_Busy),
    .M_Done  (M_Done),
    .M_Result(M_Result),
    .WA3R    (WA3R)
  );

  always #5 CLK = ~CLK;

  // Caller is just past a negedge; start is accepted at the next posedge.
  // Returns at the negedge of the done cycle (or after a timeout).
  task automatic do_op(input logic op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] wa,
                       output int done_k, output logic [31:0] res,
                       output logic [3:0] wr, output int bad);
    done_k = -1;
    res = 'x;
    wr = 'x;
    bad = 0;
    M_Start = 1'b1;
    M_Op = op;
    Operand1 = a;
    Operand2 = b;
    WA3E = wa;
    @(posedge CLK);
    #1 M_Start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (M_Busy !== (k < 32)) bad++;
      if (M_Busy === 1'b1 && M_Done === 1'b1) bad++;
      if (M_Done === 1'b1) begin
        done_k = k;
        res = M_Result;
        wr = WA3R;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    #23;
    total++;
    if ({M_Busy, M_Done} !== 2'b00)
      $display("FAIL reset_flags got=%b want=00", {M_Busy, M_Done});
    else passed++;
    total++;
    if (M_Result !== 32'd0)
      $display("FAIL reset_result got=%h want=0", M_Result);
    else passed++;
    total++;
    if (WA3R !== 4'd0)
      $display("FAIL reset_wa3r got=%h want=0", WA3R);
    else passed++;
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    total++;
    if ({M_Busy, M_Done} !== 2'b00)
      $display("FAIL idle_flags got=%b want=00", {M_Busy, M_Done});
    else passed++;
  endtask

  task automatic test_mul_basic();
    int dk, bad;
    logic [31:0] r;
    logic [3:0] w;
    do_op(1'b0, 32'd7, 32'd6, 4'd5, dk, r, w, bad);
    total++;
    if (dk !== 32) $display("FAIL mul_done_cycle got=%0d want=32", dk);
    else passed++;
    total++;
    if (r !== 32'd42) $display("FAIL mul_7x6 got=%0d want=42", r);
    else passed++;
    total++;
    if (w !== 4'd5) $display("FAIL mul_wa3r got=%0d want=5", w);
    else passed++;
    total++;
    if (bad !== 0) $display("FAIL mul_busy_shape got=%0d want=0", bad);
    else passed++;
    @(negedge CLK);
    total++;
    if ({M_Busy, M_Done} !== 2'b00)
      $display("FAIL done_one_cycle got=%b want=00", {M_Busy, M_Done});
    else passed++;
    total++;
    if (M_Result !== 32'd42)
      $display("FAIL result_hold got=%0d want=42", M_Result);
    else passed++;
  endtask

  task automatic test_boundaries();
    logic        ops [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] as  [4] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'h0001_0000};
    logic [31:0] bs  [4] = '{32'd7, 32'd1, 32'd0, 32'h0001_0000};
    logic [31:0] ex  [4] = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    int dk, bad;
    logic [31:0] r;
    logic [3:0] w;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], 4'(i + 1), dk, r, w, bad);
      total++;
      if (dk !== 32 || r !== ex[i] || w !== 4'(i + 1) || bad !== 0)
        $display("FAIL boundary_%0d got=%h@%0d wa=%0d bad=%0d want=%h@32",
                 i, r, dk, w, bad, ex[i]);
      else passed++;
    end
  endtask

  task automatic test_held_start();
    logic [31:0] prev;
    int bad, dk;
    bad = 0;
    dk = -1;
    prev = M_Result;
    M_Start = 1'b1;
    M_Op = 1'b0;
    Operand1 = 32'd7;
    Operand2 = 32'd6;
    WA3E = 4'd3;
    @(posedge CLK);
    #1;
    M_Op = 1'b1;
    Operand1 = 32'd100;
    Operand2 = 32'd7;
    WA3E = 4'd9;
    for (int k = 0; k < 32; k++) begin
      @(negedge CLK);
      if (WA3R !== 4'd3 || M_Result !== prev || M_Done !== 1'b0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL held_run_stable got=%0d want=0", bad);
    else passed++;
    @(negedge CLK);
    total++;
    if (M_Done !== 1'b1 || M_Result !== 32'd42 || WA3R !== 4'd3)
      $display("FAIL held_first_done got=%b/%0d/%0d want=1/42/3",
               M_Done, M_Result, WA3R);
    else passed++;
    @(negedge CLK);
    total++;
    if (M_Busy !== 1'b1 || WA3R !== 4'd9 || M_Result !== 32'd42)
      $display("FAIL held_accept_e33 got=%b/%0d/%0d want=1/9/42",
               M_Busy, WA3R, M_Result);
    else passed++;
    M_Start = 1'b0;
    for (int k = 34; k < 120; k++) begin
      @(negedge CLK);
      if (M_Done === 1'b1) begin
        dk = k;
        break;
      end
    end
    total++;
    if (dk !== 65 || M_Result !== 32'd14)
      $display("FAIL held_second_done got=%0d@%0d want=14@65", M_Result, dk);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    int dones, dk, bad;
    logic [31:0] r;
    logic [3:0] w;
    dones = 0;
    M_Start = 1'b1;
    M_Op = 1'b0;
    Operand1 = 32'd5;
    Operand2 = 32'd5;
    WA3E = 4'd4;
    @(posedge CLK);
    #1 M_Start = 1'b0;
    repeat (11) @(negedge CLK);
    total++;
    if (M_Busy !== 1'b1) $display("FAIL busy_cycle10 got=%b want=1", M_Busy);
    else passed++;
    RESETn = 1'b0;
    #1;
    total++;
    if ({M_Busy, M_Done, M_Result, WA3R} !== 38'd0)
      $display("FAIL abort_outputs got=%b/%b/%h/%h want=0",
               M_Busy, M_Done, M_Result, WA3R);
    else passed++;
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (40) begin
      @(negedge CLK);
      if (M_Done === 1'b1 || M_Busy === 1'b1) dones++;
    end
    total++;
    if (dones !== 0) $display("FAIL abort_no_done got=%0d want=0", dones);
    else passed++;
    do_op(1'b0, 32'd3, 32'd3, 4'd7, dk, r, w, bad);
    total++;
    if (dk !== 32 || r !== 32'd9 || w !== 4'd7 || bad !== 0)
      $display("FAIL after_abort got=%0d@%0d wa=%0d bad=%0d want=9@32",
               r, dk, w, bad);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [10] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'd12345, 32'd0, 32'hFFFF_FFFF, 32'd1000,
                            32'h8000_0000, 32'd77};
    logic [31:0] vb [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'd0, 32'd3, 32'd2, 32'd1000,
                            32'd3, 32'd1};
    logic        vo [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                            1'b0, 1'b1, 1'b1, 1'b0};
    int dk, bad;
    logic [31:0] r, a, b, exp;
    logic [3:0] w;
    logic op;
    for (int i = 0; i < 16; i++) begin
      if (i < 10) begin
        a = va[i];
        b = vb[i];
        op = vo[i];
      end else begin
        a = $urandom;
        b = (i == 12) ? 32'($urandom_range(1, 255)) : $urandom;
        op = 1'($urandom_range(0, 1));
      end
      if (op) exp = (b == 0) ? 32'hFFFF_FFFF : a / b;
      else exp = 32'(64'(a) * 64'(b));
      do_op(op, a, b, 4'(i), dk, r, w, bad);
      total++;
      if (dk !== 32 || r !== exp || w !== 4'(i) || bad !== 0)
        $display("FAIL b2b_%0d op=%b a=%h b=%h got=%h@%0d want=%h@32",
                 i, op, a, b, r, dk, exp);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_boundaries();
    test_held_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
